// File: rtl/controller_instruction_prefetch_pkg.sv
// Shared types and sizing for the controller instruction prefetch unit.
// Widths and FIFO depth are fixed here so the FIFO entry type matches everywhere.
package controller_fetch_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = PTR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 13'h0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] data;
    } fetch_entry_t;

    // Next sequential word address; wraps naturally at 2**ADDR_WIDTH
    function automatic logic [ADDR_WIDTH-1:0] pc_incr(input logic [ADDR_WIDTH-1:0] pc);
        return pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/controller_instruction_prefetch_if.sv
// ROM port-2 read bus, redirect input and instruction valid/ready stream.
// master = prefetch unit side, slave = ROM/sequencer side.
interface controller_instruction_prefetch_if;
    import controller_fetch_pkg::*;

    logic                  enable;
    logic [ADDR_WIDTH-1:0] rom_address;
    logic                  rom_chipselect;
    logic                  rom_clken;
    logic [DATA_WIDTH-1:0] rom_readdata;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        input  enable, rom_readdata, redirect_valid, redirect_pc, inst_ready,
        output rom_address, rom_chipselect, rom_clken, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output enable, rom_readdata, redirect_valid, redirect_pc, inst_ready,
        input  rom_address, rom_chipselect, rom_clken, inst_valid, inst_data, inst_pc
    );

endinterface

// File: rtl/controller_instruction_prefetch_fifo.sv
// Small synchronous FIFO of fetched words with a registered head entry.
// Flush wins over push and pop; count_next feeds the fetch credit check.
module controller_fetch_fifo
    import controller_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 push,
    input  fetch_entry_t         push_entry,
    input  logic                 pop,
    output fetch_entry_t         head,
    output logic                 head_valid,
    output logic [CNT_WIDTH-1:0] count_next
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH-1:0] ONE_PTR   = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

    fetch_entry_t         mem_r [FIFO_DEPTH];
    fetch_entry_t         head_r;
    fetch_entry_t         head_nxt_s;
    logic                 head_valid_r;
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_nxt_s;
    logic                 pop_ok_s;
    logic                 push_ok_s;

    // Qualify requests and work out next occupancy and the next head word
    always_comb begin
        pop_ok_s    = pop && (count_r != '0);
        push_ok_s   = push && ((count_r != DEPTH_CNT) || pop_ok_s);
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        if (flush) begin
            count_nxt_s = '0;
            head_nxt_s  = '0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = count_r + ONE_CNT;
                2'b01:   count_nxt_s = count_r - ONE_CNT;
                default: count_nxt_s = count_r;
            endcase
            // A word pushed into an (about to be) empty FIFO bypasses storage into the head
            if (pop_ok_s) begin
                if (count_r > ONE_CNT) begin
                    head_nxt_s = mem_r[rd_ptr_r + ONE_PTR];
                end else if (push_ok_s) begin
                    head_nxt_s = push_entry;
                end else begin
                    head_nxt_s = head_r;
                end
            end else if ((count_r == '0) && push_ok_s) begin
                head_nxt_s = push_entry;
            end else begin
                head_nxt_s = head_r;
            end
        end
    end

    // Storage, pointers, occupancy and the registered head
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            head_r       <= '0;
            head_valid_r <= 1'b0;
        end else begin
            count_r      <= count_nxt_s;
            head_r       <= head_nxt_s;
            head_valid_r <= (count_nxt_s != '0);
            if (flush) begin
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
            end else begin
                if (push_ok_s) begin
                    mem_r[wr_ptr_r] <= push_entry;
                    wr_ptr_r        <= wr_ptr_r + ONE_PTR;
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + ONE_PTR;
                end
            end
        end
    end

    assign head       = head_r;
    assign head_valid = head_valid_r;
    assign count_next = count_nxt_s;

endmodule

// File: rtl/controller_instruction_prefetch.sv
// Sequential instruction fetch from ROM port 2 with 1-cycle read latency,
// credit-limited issue into a small FIFO, and redirect flush of buffered/in-flight words.
module controller_instruction_prefetch
    import controller_fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic                                clk,
    input  logic                                reset_n,
    controller_instruction_prefetch_if.master   bus
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

    fetch_state_t          state_r;
    fetch_state_t          state_nxt_s;
    logic [ADDR_WIDTH-1:0] fetch_pc_r;
    logic [ADDR_WIDTH-1:0] rom_address_r;
    logic                  rom_cs_r;
    logic                  issue_nxt_s;
    logic                  inflight_r;
    logic                  kill_r;
    logic [ADDR_WIDTH-1:0] inflight_pc_r;
    logic                  push_s;
    logic                  pop_s;
    fetch_entry_t          push_entry_s;
    fetch_entry_t          head_s;
    logic                  head_valid_s;
    logic [CNT_WIDTH-1:0]  count_nxt_s;

    // Next state; a redirect overrides everything
    always_comb begin
        state_nxt_s = state_r;
        if (bus.redirect_valid) begin
            state_nxt_s = REDIRECT;
        end else begin
            case (state_r)
                IDLE:     state_nxt_s = bus.enable ? FETCH : IDLE;
                FETCH:    state_nxt_s = bus.enable ? FETCH : IDLE;
                REDIRECT: state_nxt_s = bus.enable ? FETCH : IDLE;
                default:  state_nxt_s = IDLE;
            endcase
        end
    end

    // Credit check for next cycle: the read issued this cycle is in flight then
    always_comb begin
        issue_nxt_s = 1'b0;
        if (state_nxt_s == FETCH) begin
            issue_nxt_s = (count_nxt_s + {{(CNT_WIDTH-1){1'b0}}, rom_cs_r}) < DEPTH_CNT;
        end else begin
            issue_nxt_s = 1'b0;
        end
    end

    // FSM, fetch pointer, registered ROM strobe/address and in-flight tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            fetch_pc_r    <= RESET_PC;
            rom_address_r <= RESET_PC;
            rom_cs_r      <= 1'b0;
            inflight_r    <= 1'b0;
            kill_r        <= 1'b0;
            inflight_pc_r <= RESET_PC;
        end else begin
            state_r       <= state_nxt_s;
            rom_cs_r      <= issue_nxt_s;
            inflight_r    <= rom_cs_r;
            kill_r        <= bus.redirect_valid;
            inflight_pc_r <= rom_address_r;
            if (bus.redirect_valid) begin
                fetch_pc_r <= bus.redirect_pc;
            end else if (issue_nxt_s) begin
                rom_address_r <= fetch_pc_r;
                fetch_pc_r    <= pc_incr(fetch_pc_r);
            end
        end
    end

    assign push_s       = inflight_r && !kill_r;
    assign pop_s        = head_valid_s && bus.inst_ready;
    assign push_entry_s = '{pc: inflight_pc_r, data: bus.rom_readdata};

    controller_fetch_fifo u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (bus.redirect_valid),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .head_valid (head_valid_s),
        .count_next (count_nxt_s)
    );

    assign bus.rom_address    = rom_address_r;
    assign bus.rom_chipselect = rom_cs_r;
    assign bus.rom_clken      = rom_cs_r;
    assign bus.inst_valid     = head_valid_s;
    assign bus.inst_data      = head_s.data;
    assign bus.inst_pc        = head_s.pc;

endmodule

// File: tb/tb_controller_instruction_prefetch.sv
// Directed bench for controller_instruction_prefetch with a 1-cycle-latency ROM model.
// ROM word[n] = TAG | n so data and pc faults are distinguishable.
module tb_controller_instruction_prefetch;
    import controller_fetch_pkg::*;

    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;
    int   issues;
    logic [DATA_WIDTH-1:0] rom_q;

    controller_instruction_prefetch_if bus();

    controller_instruction_prefetch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ROM port 2: address registered on clken, data one cycle later
    always_ff @(posedge clk) begin
        if (bus.rom_clken) rom_q <= TAG | 32'(bus.rom_address);
    end
    assign bus.rom_readdata = rom_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consume with ready=1 and check n consecutive words starting at start
    task automatic expect_stream(input logic [ADDR_WIDTH-1:0] start, input int n, input int budget);
        logic [ADDR_WIDTH-1:0] pc;
        int got;
        int cyc;
        pc  = start;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            if (bus.inst_valid) begin
                check("stream_pc", 32'(bus.inst_pc), 32'(pc));
                check("stream_data", bus.inst_data, TAG | 32'(pc));
                pc  = pc + 13'd1;
                got = got + 1;
            end
            step();
            cyc = cyc + 1;
        end
        check("stream_count", 32'(got), 32'(n));
    endtask

    initial begin
        reset_n            = 1'b0;
        bus.enable         = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        step();
        check("rst_cs",    32'(bus.rom_chipselect), 32'd0);
        check("rst_clken", 32'(bus.rom_clken),      32'd0);
        check("rst_addr",  32'(bus.rom_address),    32'd0);
        check("rst_valid", 32'(bus.inst_valid),     32'd0);
        check("rst_data",  bus.inst_data,           32'd0);
        check("rst_pc",    32'(bus.inst_pc),        32'd0);

        // Streaming from reset: first valid two cycles after entering FETCH, no gaps
        reset_n = 1'b1;
        step();
        check("t1_cs0",    32'(bus.rom_chipselect), 32'd1);
        check("t1_addr0",  32'(bus.rom_address),    32'd0);
        check("t1_valid0", 32'(bus.inst_valid),     32'd0);
        step();
        check("t1_addr1",  32'(bus.rom_address),    32'd1);
        check("t1_valid1", 32'(bus.inst_valid),     32'd0);
        step();
        check("t1_valid2", 32'(bus.inst_valid),     32'd1);
        check("t1_pc2",    32'(bus.inst_pc),        32'd0);
        check("t1_data2",  bus.inst_data,           TAG);
        for (int i = 1; i < 6; i++) begin
            step();
            check("t1_valid", 32'(bus.inst_valid), 32'd1);
            check("t1_pc",    32'(bus.inst_pc),    32'(i));
            check("t1_data",  bus.inst_data,       TAG | 32'(i));
        end

        // Consumer stalled from reset: exactly four reads, head held
        reset_n        = 1'b0;
        bus.inst_ready = 1'b0;
        step();
        reset_n = 1'b1;
        issues  = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.rom_chipselect) issues++;
        end
        check("t2_issues", 32'(issues),             32'd4);
        check("t2_cs",     32'(bus.rom_chipselect), 32'd0);
        check("t2_valid",  32'(bus.inst_valid),     32'd1);
        check("t2_pc",     32'(bus.inst_pc),        32'd0);
        check("t2_data",   bus.inst_data,           TAG);
        bus.inst_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            check("t2_valid", 32'(bus.inst_valid), 32'd1);
            check("t2_pc",    32'(bus.inst_pc),    32'(k));
        end

        // Redirect to 0x100 while the read of pc 5 is in flight
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("t3_addr5", 32'(bus.rom_address),    32'd5);
        check("t3_cs5",   32'(bus.rom_chipselect), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 13'h100;
        step();
        bus.redirect_valid = 1'b0;
        check("t3_valid_a", 32'(bus.inst_valid),     32'd0);
        check("t3_cs_a",    32'(bus.rom_chipselect), 32'd0);
        step();
        check("t3_valid_b", 32'(bus.inst_valid),     32'd0);
        check("t3_cs_b",    32'(bus.rom_chipselect), 32'd1);
        check("t3_addr_b",  32'(bus.rom_address),    32'h100);
        step();
        check("t3_valid_c", 32'(bus.inst_valid),     32'd0);
        step();
        expect_stream(13'h100, 4, 10);

        // Redirect near the top of the address space: pc wraps to 0
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 13'h1FFE;
        step();
        bus.redirect_valid = 1'b0;
        check("t4_valid", 32'(bus.inst_valid), 32'd0);
        expect_stream(13'h1FFE, 4, 12);

        // Fill the FIFO, then redirect in the same cycle as a pop
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("t5_cs",    32'(bus.rom_chipselect), 32'd0);
        check("t5_valid", 32'(bus.inst_valid),     32'd1);
        check("t5_pc",    32'(bus.inst_pc),        32'd2);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 13'h040;
        step();
        bus.redirect_valid = 1'b0;
        check("t5_valid_flush", 32'(bus.inst_valid),     32'd0);
        check("t5_cs_flush",    32'(bus.rom_chipselect), 32'd0);
        expect_stream(13'h040, 3, 12);

        // Asynchronous reset with three words buffered
        reset_n        = 1'b0;
        bus.inst_ready = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("t6_valid_pre", 32'(bus.inst_valid), 32'd1);
        check("t6_pc_pre",    32'(bus.inst_pc),    32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_valid_async", 32'(bus.inst_valid),     32'd0);
        check("t6_cs_async",    32'(bus.rom_chipselect), 32'd0);
        check("t6_pc_async",    32'(bus.inst_pc),        32'd0);
        step();
        reset_n        = 1'b1;
        bus.inst_ready = 1'b1;
        expect_stream(13'h000, 4, 12);

        // Enable drop mid-stream: buffered and in-flight words still drain
        bus.enable = 1'b0;
        expect_stream(13'h004, 3, 8);
        check("t7_valid_drained", 32'(bus.inst_valid),     32'd0);
        check("t7_cs_drained",    32'(bus.rom_chipselect), 32'd0);
        step();
        step();
        check("t7_valid_idle", 32'(bus.inst_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
